muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and HI/LO width; the iteration count SHALL equal WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: an E-stage mult/div instruction requests an operation.
REQ-005 The block SHALL have port mul0_div1_sel, input, 1 bit: 0 selects multiply, 1 selects divide; sampled with start.
REQ-006 The block SHALL have ports op_a and op_b, inputs, WIDTH bits each: multiplicand/dividend and multiplier/divisor; sampled with start.
REQ-007 The block SHALL have port hilo_rd_req, input, 1 bit: an E-stage mfhi/mflo instruction.
REQ-008 The block SHALL have port hi0_lo1_sel, input, 1 bit: selects HI (0) or LO (1) for read and write.
REQ-009 The block SHALL have ports hilo_wr_en (input, 1 bit) and hilo_wr_data (input, WIDTH bits): mthi/mtlo request and data.
REQ-010 The block SHALL have port hilo_rd_data, output, WIDTH bits: combinational HI or LO per hi0_lo1_sel.
REQ-011 The block SHALL have port stall, output, 1 bit: freezes F/D/E pipeline registers while high.
REQ-012 The block SHALL have ports busy (output, 1 bit), done (output, 1 bit, one-cycle pulse) and div_zero (output, 1 bit, pulses with done).

Function
REQ-013 The block SHALL implement FSM states IDLE and RUN.
REQ-014 In IDLE, start high at edge k SHALL latch operands and op type, clear the iteration counter, and enter RUN.
REQ-015 In RUN, the block SHALL perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 At edge k+WIDTH, the block SHALL write HI/LO and return to IDLE.
REQ-017 Multiply SHALL write HI:LO = full 2*WIDTH-bit product.
REQ-018 Divide SHALL write LO = quotient and HI = remainder.
REQ-019 busy SHALL be high exactly in RUN, i.e. the WIDTH cycles after edge k.
REQ-020 done SHALL be high for the single cycle after edge k+WIDTH.
REQ-021 Divide with op_b = 0 SHALL write LO = all ones and HI = op_a, and SHALL pulse div_zero with done.
REQ-022 stall SHALL equal busy & (start | hilo_rd_req | hilo_wr_en); these inputs SHALL be ignored while busy and accepted on the first IDLE cycle.
REQ-023 In IDLE, hilo_wr_en SHALL write hilo_wr_data to the register selected by hi0_lo1_sel at the next edge.
REQ-024 In IDLE, if start and hilo_wr_en are both high, start SHALL win and the write SHALL be dropped.
REQ-025 hilo_rd_data SHALL show previous HI/LO contents throughout RUN, and new contents from the cycle done is high.
REQ-026 Counter SHALL be $clog2(WIDTH)+1 bits; it SHALL never wrap, because the terminal count forces IDLE.

Reset
REQ-027 rst high SHALL force IDLE, counter 0, HI = LO = 0, and busy = done = div_zero = stall = 0, independent of clk.
REQ-028 rst asserted mid-operation SHALL abort the operation with no HI/LO update and no done pulse.

Configuration
REQ-029 With macro MULDIV_SIGNED_EN defined, the block SHALL add input port signed_op (1 bit, sampled with start).
REQ-030 With MULDIV_SIGNED_EN and signed_op = 1, operands SHALL be converted to magnitudes and the results negated at completion.
REQ-031 Signed divide SHALL give a quotient that truncates toward zero and a remainder that takes the dividend's sign.
REQ-032 Without MULDIV_SIGNED_EN, the block SHALL have no signed_op port, all operations SHALL be unsigned, and latency SHALL be identical.

Verification
REQ-033 The bench SHALL cover: mul 7 x 6 -> HI=0, LO=42 after 32 cycles; done pulses once; busy high 32 cycles.
REQ-034 The bench SHALL cover: unsigned mul FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-035 The bench SHALL cover: div 100 / 7 -> LO=14, HI=2; then div 5 / 0 -> LO=FFFFFFFF, HI=5, div_zero pulse.
REQ-036 The bench SHALL cover: mflo issued 3 cycles after start -> stall high 29 cycles, then hilo_rd_data = new LO, stall low.
REQ-037 The bench SHALL cover: rst at cycle 10 of a mul -> IDLE immediately, HI=LO=0, no done; next start completes normally.
REQ-038 The bench SHALL cover: MULDIV_SIGNED_EN, signed mul -6 x 7 -> HI=FFFFFFFF, LO=FFFFFFD6; signed div -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - mult/div request, HI/LO access and stall bundle
// signed_op exists only when MULDIV_SIGNED_EN is defined.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic             mul0_div1_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef MULDIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             hilo_rd_req;
  logic             hi0_lo1_sel;
  logic             hilo_wr_en;
  logic [WIDTH-1:0] hilo_wr_data;
  logic [WIDTH-1:0] hilo_rd_data;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
`ifdef MULDIV_SIGNED_EN
    output signed_op,
`endif
    output start, mul0_div1_sel, op_a, op_b,
    output hilo_rd_req, hi0_lo1_sel, hilo_wr_en, hilo_wr_data,
    input  hilo_rd_data, stall, busy, done, div_zero
  );

  modport slave (
`ifdef MULDIV_SIGNED_EN
    input  signed_op,
`endif
    input  start, mul0_div1_sel, op_a, op_b,
    input  hilo_rd_req, hi0_lo1_sel, hilo_wr_en, hilo_wr_data,
    output hilo_rd_data, stall, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative shift-add multiply / restoring divide with HI/LO registers
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 is_div, dz;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   work, work_nxt, res;
  logic [WIDTH-1:0]     hi, lo;
  logic                 done_r, dz_r;
  logic                 launch, last;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, shifted;
  logic                 borrow;
  logic [WIDTH-1:0]     sub;

`ifdef MULDIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa    = bus.signed_op & bus.op_a[WIDTH-1];
  assign sb    = bus.signed_op & bus.op_b[WIDTH-1];
  assign mag_a = sa ? -bus.op_a : bus.op_a;
  assign mag_b = sb ? -bus.op_b : bus.op_b;
`else
  assign mag_a = bus.op_a;
  assign mag_b = bus.op_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        launch    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt == CW'(WIDTH - 1)) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // work holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    add_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    shifted = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    borrow  = shifted < {1'b0, opnd};
    sub     = shifted[WIDTH-1:0] - opnd;
    if (!is_div)
      work_nxt = {add_sum, work[WIDTH-1:1]};
    else if (!borrow)
      work_nxt = {sub, work[WIDTH-2:0], 1'b1};
    else
      work_nxt = {shifted[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    res = work_nxt;
`ifdef MULDIV_SIGNED_EN
    if (!is_div) begin
      if (neg_q) res = -work_nxt;
    end else begin
      if (neg_r) res[2*WIDTH-1:WIDTH] = -work_nxt[2*WIDTH-1:WIDTH];
      if (neg_q) res[WIDTH-1:0] = -work_nxt[WIDTH-1:0];
    end
`endif
    // a zero divisor leaves the dividend in the remainder; only LO needs forcing
    if (dz) res[WIDTH-1:0] = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      opnd   <= '0;
      work   <= '0;
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      done_r <= last;
      dz_r   <= last & dz;
      if (launch) begin
        cnt    <= '0;
        is_div <= bus.mul0_div1_sel;
        dz     <= bus.mul0_div1_sel & (bus.op_b == '0);
        opnd   <= bus.mul0_div1_sel ? mag_b : mag_a;
        work   <= {{WIDTH{1'b0}}, (bus.mul0_div1_sel ? mag_a : mag_b)};
`ifdef MULDIV_SIGNED_EN
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
`endif
      end else if (state == RUN) begin
        cnt  <= cnt + CW'(1);
        work <= work_nxt;
        if (last) {hi, lo} <= res;
      end else if (bus.hilo_wr_en) begin
        if (bus.hi0_lo1_sel) lo <= bus.hilo_wr_data;
        else                 hi <= bus.hilo_wr_data;
      end
    end
  end

  assign bus.busy         = (state == RUN);
  assign bus.done         = done_r;
  assign bus.div_zero     = dz_r;
  assign bus.stall        = bus.busy & (bus.start | bus.hilo_rd_req | bus.hilo_wr_en);
  assign bus.hilo_rd_data = bus.hi0_lo1_sel ? lo : hi;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed and random checks of muldiv_ctrl against an arithmetic model
// Signed cases are included when MULDIV_SIGNED_EN is defined.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();
  muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit div, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (div && b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (div) return {32'(sa % sb), 32'(sa / sb)};
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (div) return {32'(ua % ub), 32'(ua / ub)};
    return ua * ub;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.hi0_lo1_sel = 1'b0;
    #1 h = bus.hilo_rd_data;
    bus.hi0_lo1_sel = 1'b1;
    #1 l = bus.hilo_rd_data;
  endtask

  task automatic drive_start(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start         = 1'b1;
    bus.mul0_div1_sel = div;
    bus.op_a          = a;
    bus.op_b          = b;
`ifdef MULDIV_SIGNED_EN
    bus.signed_op     = sgn;
`else
    if (sgn) $display("note: signed request in unsigned build");
`endif
    tick;
    bus.start         = 1'b0;
    bus.mul0_div1_sel = 1'($urandom);
    bus.op_a          = $urandom;
    bus.op_b          = $urandom;
  endtask

  task automatic run_op(input string tag, input bit div, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    logic [31:0] h, l;
    int          cyc;
    bit          early;
    exp = model(div, sgn, a, b);
    drive_start(div, sgn, a, b);
    cyc   = 0;
    early = 1'b0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      if (bus.done !== 1'b0) early = 1'b1;
      cyc++;
      tick;
    end
    check({tag, "/busy_cycles"}, cyc, W);
    check({tag, "/done_early"}, early, 1'b0);
    check({tag, "/done"}, bus.done, 1'b1);
    check({tag, "/div_zero"}, bus.div_zero, div && (b == 32'd0));
    read_hilo(h, l);
    check({tag, "/hi"}, h, exp[63:32]);
    check({tag, "/lo"}, l, exp[31:0]);
    tick;
    check({tag, "/done_once"}, bus.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l, wh, wl, lo_prev;
    logic [63:0] exp;
    int          cyc;
    bit          seen;

    bus.start = 1'b0; bus.mul0_div1_sel = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.hilo_rd_req = 1'b0; bus.hi0_lo1_sel = 1'b0; bus.hilo_wr_en = 1'b0; bus.hilo_wr_data = '0;
`ifdef MULDIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif

    // reset state, with requests asserted so stall would show any leak
    #1 rst = 1'b1;
    bus.start = 1'b1; bus.hilo_rd_req = 1'b1; bus.hilo_wr_en = 1'b1;
    #2;
    check("rst/busy", bus.busy, 1'b0);
    check("rst/done", bus.done, 1'b0);
    check("rst/div_zero", bus.div_zero, 1'b0);
    check("rst/stall", bus.stall, 1'b0);
    read_hilo(h, l);
    check("rst/hi", h, 32'd0);
    check("rst/lo", l, 32'd0);
    bus.start = 1'b0; bus.hilo_rd_req = 1'b0; bus.hilo_wr_en = 1'b0;
    rst = 1'b0;
    tick;

    // mthi / mtlo
    wh = $urandom; wl = $urandom;
    bus.hilo_wr_en = 1'b1; bus.hi0_lo1_sel = 1'b0; bus.hilo_wr_data = wh;
    tick;
    bus.hi0_lo1_sel = 1'b1; bus.hilo_wr_data = wl;
    tick;
    bus.hilo_wr_en = 1'b0;
    read_hilo(h, l);
    check("mthi", h, wh);
    check("mtlo", l, wl);

    // start and write together: start wins, old LO visible while running
    bus.hilo_wr_en = 1'b1; bus.hi0_lo1_sel = 1'b1; bus.hilo_wr_data = ~wl;
    drive_start(1'b0, 1'b0, 32'd3, 32'd4);
    bus.hilo_wr_en = 1'b0;
    #1 check("conflict/lo_during_run", bus.hilo_rd_data, wl);
    repeat (W) tick;
    check("conflict/done", bus.done, 1'b1);
    read_hilo(h, l);
    check("conflict/hi", h, 32'd0);
    check("conflict/lo", l, 32'd12);
    tick;

    run_op("mul7x6", 1'b0, 1'b0, 32'd7, 32'd6);
    run_op("mul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div100_7", 1'b1, 1'b0, 32'd100, 32'd7);
    run_op("div5_0", 1'b1, 1'b0, 32'd5, 32'd0);

    // mflo issued 3 cycles into a multiply stalls until completion
    read_hilo(h, lo_prev);
    exp = model(1'b0, 1'b0, 32'h0000_1234, 32'h0000_0010);
    drive_start(1'b0, 1'b0, 32'h0000_1234, 32'h0000_0010);
    tick; tick; tick;
    bus.hilo_rd_req = 1'b1; bus.hi0_lo1_sel = 1'b1;
    #1 check("stall/old_lo", bus.hilo_rd_data, lo_prev);
    cyc = 0;
    while (bus.stall === 1'b1 && cyc < 100) begin
      cyc++;
      tick;
    end
    check("stall/cycles", cyc, 29);
    check("stall/done", bus.done, 1'b1);
    check("stall/new_lo", bus.hilo_rd_data, exp[31:0]);
    check("stall/low", bus.stall, 1'b0);
    tick;
    bus.hilo_rd_req = 1'b0;

    // reset mid-operation aborts with no result and no done
    drive_start(1'b0, 1'b0, 32'd9, 32'd9);
    repeat (9) tick;
    #2 rst = 1'b1;
    #1;
    check("abort/busy", bus.busy, 1'b0);
    check("abort/stall", bus.stall, 1'b0);
    read_hilo(h, l);
    check("abort/hi", h, 32'd0);
    check("abort/lo", l, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 2) begin
      tick;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    check("abort/no_done", seen, 1'b0);
    run_op("after_abort", 1'b0, 1'b0, 32'd123, 32'd456);

`ifdef MULDIV_SIGNED_EN
    run_op("smul_m6x7", 1'b0, 1'b1, 32'hFFFF_FFFA, 32'd7);
    run_op("sdiv_m7d2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("sdiv_m7d0", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      bit          d, s;
      logic [31:0] a, b;
      d = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 4 == 3) b = 32'($urandom_range(0, 3));
      if (i % 5 == 1) a = 32'($urandom_range(0, 1000));
`ifdef MULDIV_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op($sformatf("rnd%0d", i), d, s, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
